dac_write_arbiter: RTL and testbench

DAC_WRITE_ARBITER -- requirements
Module: dac_write_arbiter

---
 rtl/dac_write_arbiter.sv | 139 +++++++++++++
 tb/tb_dac_write_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_write_arbiter.sv
// dac_write_arbiter: round-robin arbiter that drives a two-channel parallel
// DAC write cycle (chip select, write strobe, channel select, data, LDAC).
// Optional feature macro: DAC_SYNC_LOAD_EN -- when defined, LDAC is held back
// until both channels have been written, so both outputs update together.
module dac_write_arbiter #(
    parameter int SETUP_CYC = 2,
    parameter int WR_CYC    = 3,
    parameter int LDAC_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [7:0] data_a,
    input  logic       req_b,
    input  logic [7:0] data_b,
    output logic       ack_a,
    output logic       ack_b,
    output logic       busy,
    output logic       dac_csn,
    output logic       dac_wrn,
    output logic       dac_a_b,
    output logic       dac_ldacn,
    output logic [7:0] dac_d
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        WRITE = 3'd2,
        HOLD  = 3'd3,
        LOAD  = 3'd4
    } state_t;

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0] WR_LAST    = 4'(WR_CYC - 1);
    localparam logic [3:0] LDAC_LAST  = 4'(LDAC_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] phase_cnt;   // cycles spent in the current state
    logic       last_grant;  // 0 = A, 1 = B
    logic       chan_q;      // channel of the write in flight
    logic [7:0] data_q;      // code captured at grant
    logic       any_req;
    logic       grant_b;

`ifdef DAC_SYNC_LOAD_EN
    logic [1:0] pending_mask;  // channels written since the last LDAC pulse
    logic [1:0] mask_merged;
    assign mask_merged = pending_mask | (chan_q ? 2'b10 : 2'b01);
`endif

    // Round-robin pick: on a tie, the channel not granted last wins.
    assign any_req = req_a | req_b;
    assign grant_b = req_b & (~req_a | ~last_grant);

    // State register and per-state phase counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            phase_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= (state_nxt != state) ? 4'd0 : phase_cnt + 4'd1;
        end
    end

    // Next-state logic; each timed state leaves on its last phase count.
    // NOTE: state_nxt gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (any_req) state_nxt = SETUP;
            SETUP: if (phase_cnt == SETUP_LAST) state_nxt = WRITE;
            WRITE: if (phase_cnt == WR_LAST) state_nxt = HOLD;
`ifdef DAC_SYNC_LOAD_EN
            HOLD:  state_nxt = (mask_merged == 2'b11) ? LOAD : IDLE;
`else
            HOLD:  state_nxt = LOAD;
`endif
            LOAD:  if (phase_cnt == LDAC_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture: channel, code and round-robin history latch at grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            chan_q     <= 1'b0;
            data_q     <= 8'h00;
        end else if (state == IDLE && any_req) begin
            last_grant <= grant_b;
            chan_q     <= grant_b;
            data_q     <= grant_b ? data_b : data_a;
        end
    end

`ifdef DAC_SYNC_LOAD_EN
    // Pending mask: accumulate written channels, clear when LDAC is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_mask <= 2'b00;
        end else if (state == HOLD) begin
            pending_mask <= (mask_merged == 2'b11) ? 2'b00 : mask_merged;
        end
    end
`endif

    // Output decode: strobes depend only on state, so reset forces them
    // inactive immediately without waiting for a clock.
    always_comb begin
        dac_csn   = 1'b1;
        dac_wrn   = 1'b1;
        dac_ldacn = 1'b1;
        ack_a     = 1'b0;
        ack_b     = 1'b0;
        busy      = (state != IDLE);
        dac_a_b   = chan_q;
        dac_d     = data_q;
        case (state)
            SETUP: dac_csn = 1'b0;
            WRITE: begin
                dac_csn = 1'b0;
                dac_wrn = 1'b0;
            end
            HOLD: begin
                dac_csn = 1'b0;
                ack_a   = ~chan_q;
                ack_b   = chan_q;
            end
            LOAD:  dac_ldacn = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Directed bench for dac_write_arbiter (default parameters). Cycle k of a
// trace is the k-th rising edge after the request is presented; outputs are
// sampled 1 ns after that edge.
module tb_dac_write_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b;
    logic [7:0] data_a, data_b;
    logic       ack_a, ack_b, busy;
    logic       dac_csn, dac_wrn, dac_a_b, dac_ldacn;
    logic [7:0] dac_d;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        logic       ch;
        logic [7:0] d;
    } ack_ev_t;

    ack_ev_t     evq[$];
    logic [63:0] csn_v, wrn_v, ldac_v, busy_v, acka_v, ackb_v, ab_v;

    dac_write_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .data_a   (data_a),
        .req_b    (req_b),
        .data_b   (data_b),
        .ack_a    (ack_a),
        .ack_b    (ack_b),
        .busy     (busy),
        .dac_csn  (dac_csn),
        .dac_wrn  (dac_wrn),
        .dac_a_b  (dac_a_b),
        .dac_ldacn(dac_ldacn),
        .dac_d    (dac_d)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record ncyc cycles of DAC activity. With auto_drop the requester clears
    // req on the edge after it sees its ack; chg_cyc > 0 overwrites data_b
    // in that cycle.
    task automatic trace(input int ncyc, input bit auto_drop, input int chg_cyc);
        bit drop_a = 1'b0;
        bit drop_b = 1'b0;
        csn_v = '0; wrn_v = '0; ldac_v = '0; busy_v = '0;
        acka_v = '0; ackb_v = '0; ab_v = '0;
        evq.delete();
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            if (drop_a) req_a = 1'b0;
            if (drop_b) req_b = 1'b0;
            drop_a = 1'b0;
            drop_b = 1'b0;
            csn_v[k-1]  = dac_csn;
            wrn_v[k-1]  = dac_wrn;
            ldac_v[k-1] = dac_ldacn;
            busy_v[k-1] = busy;
            acka_v[k-1] = ack_a;
            ackb_v[k-1] = ack_b;
            ab_v[k-1]   = dac_a_b;
            if (ack_a || ack_b) evq.push_back('{k, ack_b, dac_d});
            if (auto_drop && ack_a) drop_a = 1'b1;
            if (auto_drop && ack_b) drop_b = 1'b1;
            if (k == chg_cyc) data_b = 8'hFF;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
        end
        check("idle_reached", busy, 0);
    endtask

    initial begin
        int         exp_cyc[4];
        logic       exp_ch[4];
        logic [7:0] exp_d[4];
        logic       seen_ack;

        rst = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        data_a = 8'h00; data_b = 8'h00;

        // Reset held with a pending request: everything inactive.
        repeat (3) @(posedge clk);
        #1;
        req_a = 1'b1;
        data_a = 8'hA5;
        #2;
        check("rst_csn", dac_csn, 1);
        check("rst_wrn", dac_wrn, 1);
        check("rst_ldacn", dac_ldacn, 1);
        check("rst_a_b", dac_a_b, 0);
        check("rst_d", dac_d, 8'h00);
        check("rst_ack", {ack_a, ack_b}, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        check("rst_hold_csn", dac_csn, 1);
        @(negedge clk) rst = 1'b1;
        #1;
        check("rel_csn_idle", dac_csn, 1);

        // Single A write: csn low 1-6, wrn low 3-5, ack 6.
        trace(10, 1'b1, 0);
        check("wr_a_csn", 32'(csn_v[9:0]), 10'h3C0);
        check("wr_a_wrn", 32'(wrn_v[9:0]), 10'h3E3);
`ifdef DAC_SYNC_LOAD_EN
        check("wr_a_ldac", 32'(ldac_v[9:0]), 10'h3FF);
        check("wr_a_busy", 32'(busy_v[9:0]), 10'h03F);
`else
        check("wr_a_ldac", 32'(ldac_v[9:0]), 10'h33F);
        check("wr_a_busy", 32'(busy_v[9:0]), 10'h0FF);
`endif
        check("wr_a_acka", 32'(acka_v[9:0]), 10'h020);
        check("wr_a_ackb", 32'(ackb_v[9:0]), 10'h000);
        check("wr_a_ab", 32'(ab_v[9:0]), 10'h000);
        check("wr_a_nack", evq.size(), 1);
        if (evq.size() > 0) check("wr_a_d", evq[0].d, 8'hA5);
        wait_idle();

`ifdef DAC_SYNC_LOAD_EN
        // Only after both channels are written does LDAC pulse.
        check("mask_after_a", dut.pending_mask, 2'b01);
        req_b = 1'b1;
        data_b = 8'h20;
        trace(10, 1'b1, 0);
        check("sync_b_ldac", 32'(ldac_v[9:0]), 10'h33F);
        check("sync_b_ackb", 32'(ackb_v[9:0]), 10'h020);
        check("sync_b_nack", evq.size(), 1);
        if (evq.size() > 0) check("sync_b_d", evq[0].d, 8'h20);
        check("mask_after_b", dut.pending_mask, 2'b00);
        wait_idle();
`else
        // B write with data changing during WRITE: captured code wins.
        req_b = 1'b1;
        data_b = 8'h40;
        trace(10, 1'b1, 4);
        check("chg_ackb", 32'(ackb_v[9:0]), 10'h020);
        check("chg_acka", 32'(acka_v[9:0]), 10'h000);
        check("chg_nack", evq.size(), 1);
        if (evq.size() > 0) begin
            check("chg_d", evq[0].d, 8'h40);
            check("chg_ch", evq[0].ch, 1);
        end
        wait_idle();

        // Contention, both held high: A, B, A, B every 9 cycles.
        req_a = 1'b1; data_a = 8'h11;
        req_b = 1'b1; data_b = 8'h22;
        exp_cyc = '{6, 15, 24, 33};
        exp_ch  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_d   = '{8'h11, 8'h22, 8'h11, 8'h22};
        trace(33, 1'b0, 0);
        req_a = 1'b0;
        req_b = 1'b0;
        check("rr_nack", evq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < evq.size()) begin
                check($sformatf("rr%0d_cyc", i), evq[i].cyc, exp_cyc[i]);
                check($sformatf("rr%0d_ch", i), evq[i].ch, exp_ch[i]);
                check($sformatf("rr%0d_d", i), evq[i].d, exp_d[i]);
            end
        end
        wait_idle();
`endif

        // Reset in the middle of WRITE: strobes go inactive at once, no ack.
        req_a = 1'b1;
        data_a = 8'h5A;
        repeat (4) @(posedge clk);
        #1;
        check("mid_in_write", dac_wrn, 0);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_csn", dac_csn, 1);
        check("mid_rst_wrn", dac_wrn, 1);
        check("mid_rst_ldacn", dac_ldacn, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_d", dac_d, 8'h00);
        req_a = 1'b0;
        seen_ack = ack_a;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen_ack |= ack_a;
        end
        check("mid_rst_noack", seen_ack, 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rel_idle", busy, 0);

        // After reset, last grant is B again so A wins a tie.
        req_a = 1'b1; data_a = 8'h11;
        req_b = 1'b1; data_b = 8'h22;
        trace(8, 1'b1, 0);
        req_b = 1'b0;
        check("tie_nack", (evq.size() >= 1) ? 1 : 0, 1);
        if (evq.size() > 0) begin
            check("tie_cyc", evq[0].cyc, 6);
            check("tie_ch", evq[0].ch, 0);
            check("tie_d", evq[0].d, 8'h11);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
